// File: rtl/ex_mem_stage_buf.sv
// ex_mem_stage_buf: elastic EX/MEM stage, 2-entry skid buffer with flush, forwarding tap and stall counter
module ex_mem_stage_buf #(
    parameter int DATA_W       = 32,
    parameter int RA_W         = 5,
    parameter int CTRL_W       = 8,
    parameter int REGWRITE_BIT = 1,
    parameter int F3_W         = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_store,
    input  logic [RA_W-1:0]   in_rd,
    input  logic [F3_W-1:0]   in_f3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_store,
    output logic [RA_W-1:0]   out_rd,
    output logic [F3_W-1:0]   out_f3,
    output logic              fwd_en,
    output logic [RA_W-1:0]   fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int PW = CTRL_W + 2 * DATA_W + RA_W + F3_W;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t        state;
    logic [PW-1:0] main_q, skid_q, in_bus;
    logic          main_valid, skid_valid, in_fire;

    assign main_valid = state == ONE || state == FULL;
    assign skid_valid = state == FULL;
    // ready depends only on held state, so MEM back-pressure never reaches EX combinationally
    assign in_ready   = !skid_valid && !rst;
    assign in_fire    = in_valid && in_ready;
    assign out_valid  = main_valid;
    assign in_bus     = {in_ctrl, in_alu, in_store, in_rd, in_f3};
    assign {out_ctrl, out_alu, out_store, out_rd, out_f3} = main_q;
    assign fwd_en     = out_valid && out_ctrl[REGWRITE_BIT] && out_rd != '0;
    assign fwd_rd     = out_rd;
    assign fwd_data   = out_alu;
    assign occupancy  = {1'b0, main_valid} + {1'b0, skid_valid};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (flush) begin
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: if (in_fire) begin
                        main_q <= in_bus;
                        state  <= ONE;
                    end
                    ONE: if (in_fire && out_ready) begin
                        main_q <= in_bus;
                    end else if (in_fire) begin
                        skid_q <= in_bus;
                        state  <= FULL;
                    end else if (out_ready) begin
                        state <= EMPTY;
                    end
                    FULL: if (out_ready) begin
                        main_q <= skid_q;
                        state  <= ONE;
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// tb_ex_mem_stage_buf: directed self-checking bench for ex_mem_stage_buf (CNT_W = 4 to reach saturation)
module tb_ex_mem_stage_buf;
    logic        clk = 0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, fwd_en;
    logic [7:0]  in_ctrl, out_ctrl;
    logic [31:0] in_alu, in_store, out_alu, out_store, fwd_data;
    logic [4:0]  in_rd, out_rd, fwd_rd;
    logic [3:0]  in_f3, out_f3, stall_cnt;
    logic [1:0]  occupancy;
    int          n_checks = 0;
    int          n_fail = 0;

    ex_mem_stage_buf #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_alu(in_alu), .in_store(in_store), .in_rd(in_rd), .in_f3(in_f3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_alu(out_alu), .out_store(out_store), .out_rd(out_rd), .out_f3(out_f3),
        .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] alu, input logic [4:0] rd, input logic [7:0] ctrl);
        in_valid = 1;
        in_alu   = alu;
        in_rd    = rd;
        in_ctrl  = ctrl;
    endtask

    initial begin
        rst = 1; flush = 0; in_valid = 0; out_ready = 0;
        in_ctrl = 0; in_alu = 0; in_store = 0; in_rd = 0; in_f3 = 0;
        #3;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_out_alu", out_alu, 0);
        chk("rst_fwd_en", fwd_en, 0);
        step();
        rst = 0;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // stream one entry
        out_ready = 1;
        send(32'hA, 5'd1, 8'h02);
        step();
        in_valid = 0;
        chk("s_out_valid", out_valid, 1);
        chk("s_out_alu", out_alu, 32'hA);
        chk("s_fwd_en", fwd_en, 1);
        chk("s_fwd_rd", fwd_rd, 1);
        chk("s_fwd_data", fwd_data, 32'hA);
        step();
        chk("s_drained", out_valid, 0);
        chk("s_stall", stall_cnt, 0);

        // back-pressure
        out_ready = 0;
        send(32'hA, 5'd2, 8'h02);
        step();
        chk("bp_occ1", occupancy, 1);
        chk("bp_stall0", stall_cnt, 0);
        send(32'hC, 5'd3, 8'h02);
        step();
        in_valid = 0;
        chk("bp_occ2", occupancy, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_stall1", stall_cnt, 1);
        step();
        chk("bp_stall2", stall_cnt, 2);
        chk("bp_head", out_alu, 32'hA);
        out_ready = 1;
        step();
        chk("bp_second", out_alu, 32'hC);
        chk("bp_second_rd", out_rd, 3);
        chk("bp_ready_back", in_ready, 1);
        chk("bp_occ_after", occupancy, 1);
        chk("bp_stall_hold", stall_cnt, 2);
        step();
        chk("bp_empty", occupancy, 0);

        // flush while full
        out_ready = 0;
        send(32'h1, 5'd4, 8'h02);
        step();
        send(32'h2, 5'd5, 8'h02);
        step();
        chk("fl_full", occupancy, 2);
        send(32'hF, 5'd6, 8'h02);
        flush = 1;
        step();
        flush = 0;
        in_valid = 0;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_occ", occupancy, 0);
        chk("fl_stall", stall_cnt, 4);
        step();
        chk("fl_no_f", out_valid, 0);
        chk("fl_ready", in_ready, 1);

        // x0 suppression and replacement in ONE
        out_ready = 1;
        send(32'h10, 5'd0, 8'h02);
        in_store = 32'h55; in_f3 = 4'd3;
        step();
        chk("x0_valid", out_valid, 1);
        chk("x0_alu", out_alu, 32'h10);
        chk("x0_fwd_en", fwd_en, 0);
        chk("x0_store", out_store, 32'h55);
        chk("x0_f3", out_f3, 3);
        send(32'h11, 5'd7, 8'h00);
        step();
        in_valid = 0;
        chk("nw_alu", out_alu, 32'h11);
        chk("nw_rd", out_rd, 7);
        chk("nw_fwd_en", fwd_en, 0);
        chk("nw_occ", occupancy, 1);
        step();
        chk("nw_empty", out_valid, 0);

        // async reset while full
        out_ready = 0;
        send(32'h21, 5'd8, 8'h02);
        step();
        send(32'h22, 5'd9, 8'h02);
        step();
        in_valid = 0;
        chk("ar_full", occupancy, 2);
        chk("ar_stall_pre", stall_cnt, 5);
        #2 rst = 1;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_occ", occupancy, 0);
        chk("ar_stall", stall_cnt, 0);
        chk("ar_in_ready", in_ready, 0);
        #1 rst = 0;
        #1;
        chk("ar_rel_ready", in_ready, 1);

        // stall counter saturation
        send(32'h33, 5'd10, 8'h02);
        step();
        in_valid = 0;
        repeat (5) step();
        chk("sat_mid", stall_cnt, 5);
        repeat (15) step();
        chk("sat_top", stall_cnt, 15);
        chk("sat_head", out_alu, 32'h33);
        chk("sat_occ", occupancy, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_mem_stage_buf.md
Name: ex_mem_stage_buf

Overview:
- Parametrised, elastic EX/MEM pipeline stage. Successor to the fixed-width EX/MEM register.
- Captures the EX-stage result bundle: control bits, ALU result, store data, destination register and funct3.
- Holds the bundle in a 2-entry skid buffer with valid/ready handshake, synchronous flush, forwarding tap and stall counter.
- Sits between the ALU/EX stage and data memory. Lets MEM back-pressure EX without a combinational ready path.

Parameters:
- DATA_W, 32, width of ALU result and store data.
- RA_W, 5, register-address width.
- CTRL_W, 8, width of the packed control bundle (memtoreg, regwrite, memread, memwrite, AJ_control, ...).
- REGWRITE_BIT, 1, index of regwrite inside the control bundle.
- F3_W, 4, funct3 field width.
- CNT_W, 16, stall-counter width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  EX bundle valid
- in_ready  out  1  stage can accept
- in_ctrl  in  CTRL_W  control bundle
- in_alu  in  DATA_W  ALU result
- in_store  in  DATA_W  store data (readdata2)
- in_rd  in  RA_W  destination register
- in_f3  in  F3_W  funct3
- out_valid  out  1  head entry valid
- out_ready  in  1  MEM stage accepts head
- out_ctrl, out_alu, out_store, out_rd, out_f3  out  as inputs  head-entry payload
- fwd_en  out  1  head entry will write a non-zero register
- fwd_rd  out  RA_W  forwarding register address
- fwd_data  out  DATA_W  forwarding data (out_alu)
- occupancy  out  2  entries held (0..2)
- stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Storage: main entry (drives out_*) and skid entry. Each has a valid flag.
- States:
  - EMPTY: no entries held.
  - ONE: main entry valid.
  - FULL: main and skid entries valid.
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !skid_valid, driven from a register only (no combinational path from out_ready).
- out_valid = main_valid.
- Transitions when flush = 0:
  - EMPTY: in_fire → main <= input; go to ONE.
  - ONE, in_fire & out_fire → main <= input; stay ONE.
  - ONE, in_fire & !out_ready → skid <= input; go to FULL.
  - ONE, out_fire only → go to EMPTY.
  - ONE, neither → hold.
  - FULL: in_ready = 0. out_fire → main <= skid, skid_valid <= 0, go to ONE. No out_fire → hold.
- Latency: 1 cycle, input handshake to out_valid, when the stage is EMPTY or draining.
- Ordering is strictly FIFO. No entry is dropped or duplicated.
- Flush has priority over everything:
  - Next edge: main_valid = skid_valid = 0; state EMPTY.
  - Any in_fire in the same cycle is discarded.
  - Payload registers keep stale values; consumers must qualify with out_valid.
- Forwarding tap:
  - fwd_en = out_valid & out_ctrl[REGWRITE_BIT] & (out_rd != 0).
  - fwd_rd = out_rd; fwd_data = out_alu.
  - Combinational from the head entry.
- occupancy = main_valid + skid_valid.
- stall_cnt:
  - Increments by 1 on each edge where out_valid & !out_ready.
  - Saturates at all-ones.
  - Unaffected by flush; cleared only by rst.
- Reset (asynchronous, active-high) forces:
  - All valids 0, payload registers 0, stall_cnt 0, state EMPTY.
  - Outputs: in_ready 0 while rst is high, 1 on the first cycle after release; out_valid 0; fwd_en 0; occupancy 0.
- Reset mid-operation discards all held entries immediately, with no wait for a clock edge.
- Simultaneous in_fire and out_fire in ONE is one replacement, not a pass-through. FULL is never entered in that case.

Test Plan:
- Reset then stream: rst pulse; present in_alu = 0xA, in_rd = 1, ctrl regwrite = 1 with out_ready = 1 → out_valid and out_alu = 0xA one cycle later; fwd_en = 1, fwd_rd = 1.
- Back-pressure: out_ready = 0; send alu 0xA then 0xC → occupancy = 2, in_ready = 0, stall_cnt increments each cycle. Raise out_ready → 0xA then 0xC emerge in order; in_ready returns to 1 after the first drain.
- Flush while FULL: two entries held; assert flush together with in_valid (alu 0xF) → next cycle out_valid = 0, occupancy = 0; 0xF never appears.
- x0 suppression: in_rd = 0, regwrite = 1, alu 0x10 → out_valid = 1 with fwd_en = 0. Regwrite = 0 with rd = 7 also gives fwd_en = 0.
- Async reset mid-stream: assert rst between edges while FULL → out_valid, occupancy and stall_cnt go to 0 immediately, without a clock edge.
- Counter saturation: CNT_W = 4, hold out_ready = 0 with an entry present for 20 cycles → stall_cnt stops at 15.
